// File: rtl/prefix_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : prefix_adder_pipe (plus the cells it is built from)
// Purpose  : Two-stage pipelined Kogge-Stone add/subtract unit with
//            valid/ready handshakes on both sides. The prefix tree is split
//            across the pipeline register so that neither stage carries the
//            full log2(WIDTH)-level carry network.
// Ports    : i_clk, i_reset (async, active-high)
//            i_valid/o_ready, i_a, i_b, i_sub       - operand side
//            o_valid/i_ready, o_sum, o_cout,
//            o_overflow, o_zero                     - result side
// Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Bit-level propagate/generate cell. For subtraction the B operand is
// inverted here; the +1 is supplied as the carry-in node of the tree.
// ----------------------------------------------------------------------------
module prefix_adder_pipe_pg (
    input  logic i_a,
    input  logic i_b,
    input  logic i_inv,
    output logic o_p,
    output logic o_g
);
    logic w_b;
    assign w_b = i_b ^ i_inv;
    assign o_p = i_a ^ w_b;
    assign o_g = i_a & w_b;
endmodule

// ----------------------------------------------------------------------------
// Carry-combine (black) cell: merges a high group with the adjacent low group.
// ----------------------------------------------------------------------------
module prefix_adder_pipe_combine (
    input  logic i_g_hi,
    input  logic i_p_hi,
    input  logic i_g_lo,
    input  logic i_p_lo,
    output logic o_g,
    output logic o_p
);
    assign o_g = i_g_hi | (i_p_hi & i_g_lo);
    assign o_p = i_p_hi & i_p_lo;
endmodule

// ----------------------------------------------------------------------------
// Sum cell: result bit from the bit propagate and the incoming carry.
// ----------------------------------------------------------------------------
module prefix_adder_pipe_sum (
    input  logic i_p,
    input  logic i_c,
    output logic o_s
);
    assign o_s = i_p ^ i_c;
endmodule

// ----------------------------------------------------------------------------
// One Kogge-Stone level. Node j combines with node j-DIST; nodes below DIST
// already reach the carry-in node and pass straight through.
// ----------------------------------------------------------------------------
module prefix_adder_pipe_level #(
    parameter int NODES = 33,
    parameter int DIST  = 1
) (
    input  logic [NODES-1:0] i_g,
    input  logic [NODES-1:0] i_p,
    output logic [NODES-1:0] o_g,
    output logic [NODES-1:0] o_p
);
    genvar j;
    generate
        for (j = 0; j < NODES; j = j + 1) begin : g_node
            if (j >= DIST) begin : g_cmb
                prefix_adder_pipe_combine u_cmb (
                    .i_g_hi (i_g[j]),
                    .i_p_hi (i_p[j]),
                    .i_g_lo (i_g[j-DIST]),
                    .i_p_lo (i_p[j-DIST]),
                    .o_g    (o_g[j]),
                    .o_p    (o_p[j])
                );
            end else begin : g_pass
                assign o_g[j] = i_g[j];
                assign o_p[j] = i_p[j];
            end
        end
    endgenerate
endmodule

// ----------------------------------------------------------------------------
// Top level
// ----------------------------------------------------------------------------
module prefix_adder_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_overflow,
    output logic             o_zero
);
    // Node 0 is the carry-in position (bit -1); node i+1 holds bit i.
    localparam int c_NODES     = WIDTH + 1;
    localparam int c_LEVELS    = $clog2(WIDTH);
    localparam int c_S1_LEVELS = c_LEVELS / 2;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s1_load;
    logic w_s2_load;

    assign w_s2_load = r_s1_valid & (~r_s2_valid | i_ready);
    assign o_ready   = ~r_s1_valid | w_s2_load;
    assign w_s1_load = i_valid & o_ready;

    // ------------------------------------------------------------------
    // Stage 1: pg generation and the lower half of the prefix levels
    // ------------------------------------------------------------------
    wire [c_NODES-1:0] w_g1 [0:c_S1_LEVELS];
    wire [c_NODES-1:0] w_p1 [0:c_S1_LEVELS];
    wire [WIDTH-1:0]   w_pb;

    // Carry-in folded in as a generate-only node: g[-1]=cin, p[-1]=0.
    assign w_g1[0][0] = i_sub;
    assign w_p1[0][0] = 1'b0;

    genvar i;
    genvar k;
    generate
        for (i = 0; i < WIDTH; i = i + 1) begin : g_pg
            prefix_adder_pipe_pg u_pg (
                .i_a   (i_a[i]),
                .i_b   (i_b[i]),
                .i_inv (i_sub),
                .o_p   (w_p1[0][i+1]),
                .o_g   (w_g1[0][i+1])
            );
            assign w_pb[i] = w_p1[0][i+1];
        end

        for (k = 1; k <= c_S1_LEVELS; k = k + 1) begin : g_s1_lvl
            prefix_adder_pipe_level #(
                .NODES (c_NODES),
                .DIST  (1 << (k - 1))
            ) u_lvl (
                .i_g (w_g1[k-1]),
                .i_p (w_p1[k-1]),
                .o_g (w_g1[k]),
                .o_p (w_p1[k])
            );
        end
    endgenerate

    logic [c_NODES-1:0] r_s1_g;
    logic [c_NODES-1:0] r_s1_p;
    logic [WIDTH-1:0]   r_s1_pb;

    // Data only moves on a load, so it is frozen whenever stage 1 stalls.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_s1_valid <= 1'b0;
            r_s1_g     <= '0;
            r_s1_p     <= '0;
            r_s1_pb    <= '0;
        end else begin
            r_s1_valid <= w_s1_load | (r_s1_valid & ~w_s2_load);
            if (w_s1_load) begin
                r_s1_g  <= w_g1[c_S1_LEVELS];
                r_s1_p  <= w_p1[c_S1_LEVELS];
                r_s1_pb <= w_pb;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: remaining prefix levels, carries, sum and flags
    // ------------------------------------------------------------------
    wire [c_NODES-1:0] w_g2 [c_S1_LEVELS:c_LEVELS];
    wire [c_NODES-1:0] w_p2 [c_S1_LEVELS:c_LEVELS];

    assign w_g2[c_S1_LEVELS] = r_s1_g;
    assign w_p2[c_S1_LEVELS] = r_s1_p;

    generate
        for (k = c_S1_LEVELS + 1; k <= c_LEVELS; k = k + 1) begin : g_s2_lvl
            prefix_adder_pipe_level #(
                .NODES (c_NODES),
                .DIST  (1 << (k - 1))
            ) u_lvl (
                .i_g (w_g2[k-1]),
                .i_p (w_p2[k-1]),
                .o_g (w_g2[k]),
                .o_p (w_p2[k])
            );
        end
    endgenerate

    // After log2(WIDTH) levels every node below WIDTH spans down to the
    // carry-in node. The top node spans WIDTH nodes, one short of the
    // carry-in, so it takes one extra combine with node 0 to form cout.
    logic [WIDTH:0]   w_carry;
    logic             w_top_p;
    logic [WIDTH-1:0] w_sum;

    assign w_carry[WIDTH-1:0] = w_g2[c_LEVELS][WIDTH-1:0];

    prefix_adder_pipe_combine u_cout (
        .i_g_hi (w_g2[c_LEVELS][WIDTH]),
        .i_p_hi (w_p2[c_LEVELS][WIDTH]),
        .i_g_lo (w_g2[c_LEVELS][0]),
        .i_p_lo (w_p2[c_LEVELS][0]),
        .o_g    (w_carry[WIDTH]),
        .o_p    (w_top_p)
    );

    // Group propagates of the final level are only needed at the top node.
    logic w_unused_p;
    assign w_unused_p = ^{w_p2[c_LEVELS], w_top_p};

    generate
        for (i = 0; i < WIDTH; i = i + 1) begin : g_sum
            prefix_adder_pipe_sum u_sum (
                .i_p (r_s1_pb[i]),
                .i_c (w_carry[i]),
                .o_s (w_sum[i])
            );
        end
    endgenerate

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_overflow;
    logic             r_zero;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_s2_valid <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            r_s2_valid <= w_s2_load | (r_s2_valid & ~i_ready);
            if (w_s2_load) begin
                r_sum      <= w_sum;
                r_cout     <= w_carry[WIDTH];
                r_overflow <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
                r_zero     <= ~|w_sum;
            end
        end
    end

    assign o_valid    = r_s2_valid;
    assign o_sum      = r_sum;
    assign o_cout     = r_cout;
    assign o_overflow = r_overflow;
    assign o_zero     = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_prefix_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_prefix_adder_pipe
// Purpose  : Directed self-checking bench for prefix_adder_pipe (WIDTH=32):
//            single-beat arithmetic corners, a back-to-back stream,
//            output back-pressure and an asynchronous mid-flight reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_prefix_adder_pipe;

    localparam int c_W = 32;

    logic           clk;
    logic           r_reset;
    logic           r_valid;
    logic [c_W-1:0] r_a;
    logic [c_W-1:0] r_b;
    logic           r_sub;
    logic           r_ready;
    logic           w_ready;
    logic           w_valid;
    logic [c_W-1:0] w_sum;
    logic           w_cout;
    logic           w_overflow;
    logic           w_zero;

    int n_tests;
    int n_fail;

    prefix_adder_pipe #(.WIDTH(c_W)) u_dut (
        .i_clk      (clk),
        .i_reset    (r_reset),
        .i_valid    (r_valid),
        .o_ready    (w_ready),
        .i_a        (r_a),
        .i_b        (r_b),
        .i_sub      (r_sub),
        .o_valid    (w_valid),
        .i_ready    (r_ready),
        .o_sum      (w_sum),
        .o_cout     (w_cout),
        .o_overflow (w_overflow),
        .o_zero     (w_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One beat in, checked two cycles later with i_ready held high.
    task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [31:0] e_sum, input logic e_cout,
                          input logic e_ovf, input logic e_zero);
        @(negedge clk);
        r_ready = 1'b1;
        r_valid = 1'b1;
        r_a     = a;
        r_b     = b;
        r_sub   = sub;
        check({tag, "_rdy"}, w_ready, 1'b1);
        @(negedge clk);
        r_valid = 1'b0;
        check({tag, "_lat1"}, w_valid, 1'b0);
        @(negedge clk);
        check({tag, "_valid"}, w_valid, 1'b1);
        check({tag, "_sum"},   w_sum,   e_sum);
        check({tag, "_cout"},  w_cout,  e_cout);
        check({tag, "_ovf"},   w_overflow, e_ovf);
        check({tag, "_zero"},  w_zero,  e_zero);
    endtask

    // Stream vectors with hand-computed results.
    logic [31:0] tv_a   [8];
    logic [31:0] tv_b   [8];
    logic        tv_sub [8];
    logic [31:0] tv_sum [8];
    logic        tv_co  [8];

    initial begin
        tv_a[0] = 32'h0000_0001; tv_b[0] = 32'h0000_0002; tv_sub[0] = 1'b0; tv_sum[0] = 32'h0000_0003; tv_co[0] = 1'b0;
        tv_a[1] = 32'h0000_000A; tv_b[1] = 32'h0000_0003; tv_sub[1] = 1'b1; tv_sum[1] = 32'h0000_0007; tv_co[1] = 1'b1;
        tv_a[2] = 32'hFFFF_FFFF; tv_b[2] = 32'hFFFF_FFFF; tv_sub[2] = 1'b0; tv_sum[2] = 32'hFFFF_FFFE; tv_co[2] = 1'b1;
        tv_a[3] = 32'h0000_0100; tv_b[3] = 32'h0000_0001; tv_sub[3] = 1'b1; tv_sum[3] = 32'h0000_00FF; tv_co[3] = 1'b1;
        tv_a[4] = 32'hAAAA_AAAA; tv_b[4] = 32'h5555_5555; tv_sub[4] = 1'b0; tv_sum[4] = 32'hFFFF_FFFF; tv_co[4] = 1'b0;
        tv_a[5] = 32'h0000_0000; tv_b[5] = 32'h0000_0001; tv_sub[5] = 1'b1; tv_sum[5] = 32'hFFFF_FFFF; tv_co[5] = 1'b0;
        tv_a[6] = 32'h0F0F_0F0F; tv_b[6] = 32'h0101_0101; tv_sub[6] = 1'b0; tv_sum[6] = 32'h1010_1010; tv_co[6] = 1'b0;
        tv_a[7] = 32'hDEAD_BEEF; tv_b[7] = 32'hDEAD_BEEF; tv_sub[7] = 1'b1; tv_sum[7] = 32'h0000_0000; tv_co[7] = 1'b1;
    end

    initial begin
        int out_idx;
        n_tests = 0;
        n_fail  = 0;
        r_reset = 1'b1;
        r_valid = 1'b0;
        r_a     = '0;
        r_b     = '0;
        r_sub   = 1'b0;
        r_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", w_valid, 1'b0);
        check("rst_sum",   w_sum,   32'h0);
        check("rst_cout",  w_cout,  1'b0);
        check("rst_ovf",   w_overflow, 1'b0);
        check("rst_zero",  w_zero,  1'b0);
        r_reset = 1'b0;
        @(negedge clk);
        check("rst_ready", w_ready, 1'b1);

        // Arithmetic corners
        single("t1_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        single("t2_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        single("t3_posovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        single("t3_negovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        single("t_zsub",    32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        single("t_minmin",  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        single("t_mixed",   32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

        // Back-to-back stream: beat driven at cycle c appears at cycle c+2.
        out_idx = 0;
        r_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            check("strm_valid", w_valid, (cyc >= 2 && cyc < 10));
            if (w_valid && out_idx < 8) begin
                check("strm_sum",  w_sum,  tv_sum[out_idx]);
                check("strm_cout", w_cout, tv_co[out_idx]);
                out_idx++;
            end
            if (cyc < 8) begin
                check("strm_rdy", w_ready, 1'b1);
                r_valid = 1'b1;
                r_a     = tv_a[cyc];
                r_b     = tv_b[cyc];
                r_sub   = tv_sub[cyc];
            end else begin
                r_valid = 1'b0;
            end
        end
        check("strm_count", out_idx, 8);

        // Back-pressure: two beats fill the pipe, a third is held by the source.
        @(negedge clk);
        r_ready = 1'b0;
        r_valid = 1'b1; r_a = 32'd100; r_b = 32'd200; r_sub = 1'b0;
        check("bp_rdy0", w_ready, 1'b1);
        @(negedge clk);
        check("bp_rdy1", w_ready, 1'b1);
        r_a = 32'h0000_1000; r_b = 32'h0000_0001; r_sub = 1'b1;
        @(negedge clk);
        r_a = 32'd7; r_b = 32'd8; r_sub = 1'b0;
        for (int n = 0; n < 5; n++) begin
            check("bp_stall_rdy", w_ready, 1'b0);
            check("bp_stall_vld", w_valid, 1'b1);
            check("bp_stall_sum", w_sum, 32'd300);
            @(negedge clk);
        end
        r_ready = 1'b1;
        @(negedge clk);
        r_valid = 1'b0;
        check("bp_out2_vld", w_valid, 1'b1);
        check("bp_out2_sum", w_sum, 32'h0000_0FFF);
        @(negedge clk);
        check("bp_out3_vld", w_valid, 1'b1);
        check("bp_out3_sum", w_sum, 32'd15);
        @(negedge clk);
        check("bp_drained", w_valid, 1'b0);

        // Asynchronous reset with two beats in flight.
        r_ready = 1'b0;
        r_valid = 1'b1; r_a = 32'd1; r_b = 32'd1; r_sub = 1'b0;
        @(negedge clk);
        r_a = 32'd2; r_b = 32'd2;
        @(negedge clk);
        r_valid = 1'b0;
        check("ar_full_vld", w_valid, 1'b1);
        #2;
        r_reset = 1'b1;
        #1;
        check("ar_vld_now", w_valid, 1'b0);
        check("ar_sum_now", w_sum, 32'h0);
        @(negedge clk);
        #2;
        r_reset = 1'b0;
        r_ready = 1'b1;
        @(negedge clk);
        check("ar_ready", w_ready, 1'b1);
        check("ar_no_ghost", w_valid, 1'b0);
        @(negedge clk);
        check("ar_no_ghost2", w_valid, 1'b0);
        single("ar_after", 32'h0000_0009, 32'h0000_0004, 1'b1, 32'h0000_0005, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("ar_final_empty", w_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
